// File: rtl/frame_loader.sv
`timescale 1ns/1ps
// Receive-side frame assembler: packs UART bytes into the hidden bank of a
// double-buffered frame RAM, zero-pads timed-out frames, then swaps banks.
module frame_loader #(
  parameter int PIXELS         = 256,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       wr_en,
  output logic       wr_bank,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       disp_bank,
  output logic       frame_done,
  output logic       timeout,
  output logic       overrun,
  output logic [1:0] led_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FILL, S_SWAP, S_DISPLAY
  } state_t;

  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [8:0]     LAST_PIX = 9'(PIXELS - 1);
  localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]     LED_IDLE = 2'b00;
  localparam logic [1:0]     LED_LOAD = 2'b01;
  localparam logic [1:0]     LED_DISP = 2'b10;

  state_t        r_state;
  logic [8:0]    r_byte_cnt;
  logic [TW-1:0] r_to_cnt;
  logic          r_wr_en;
  logic [7:0]    r_wr_addr;
  logic [7:0]    r_wr_data;
  logic          r_disp_bank;
  logic          r_frame_done;
  logic          r_timeout;
  logic          r_overrun;
  logic [1:0]    r_led;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_byte_cnt   <= '0;
      r_to_cnt     <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_disp_bank  <= 1'b0;
      r_frame_done <= 1'b0;
      r_timeout    <= 1'b0;
      r_overrun    <= 1'b0;
      r_led        <= LED_IDLE;
    end else begin
      // NOTE: strobes default low here with <=, so any branch below that
      // raises one overrides it and each pulse lasts exactly one cycle.
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_timeout    <= 1'b0;
      r_overrun    <= 1'b0;

      case (r_state)
        S_IDLE, S_DISPLAY: begin
          if (rx_valid) begin
            r_wr_en    <= 1'b1;
            r_wr_addr  <= '0;
            r_wr_data  <= rx_data;
            r_byte_cnt <= 9'd1;
            r_to_cnt   <= '0;
            r_led      <= LED_LOAD;
            r_state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          // A byte arriving in the expiry cycle wins over the timeout.
          if (rx_valid) begin
            r_wr_en    <= 1'b1;
            r_wr_addr  <= r_byte_cnt[7:0];
            r_wr_data  <= rx_data;
            r_byte_cnt <= r_byte_cnt + 9'd1;
            r_to_cnt   <= '0;
            if (r_byte_cnt == LAST_PIX) r_state <= S_SWAP;
          end else if (r_to_cnt == TO_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_FILL;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        S_FILL: begin
          r_wr_en    <= 1'b1;
          r_wr_addr  <= r_byte_cnt[7:0];
          r_wr_data  <= '0;
          r_byte_cnt <= r_byte_cnt + 9'd1;
          r_overrun  <= rx_valid;
          if (r_byte_cnt == LAST_PIX) r_state <= S_SWAP;
        end

        S_SWAP: begin
          r_disp_bank  <= ~r_disp_bank;
          r_frame_done <= 1'b1;
          r_overrun    <= rx_valid;
          r_led        <= LED_DISP;
          r_state      <= S_DISPLAY;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_bank    = ~r_disp_bank;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign disp_bank  = r_disp_bank;
  assign frame_done = r_frame_done;
  assign timeout    = r_timeout;
  assign overrun    = r_overrun;
  assign led_state  = r_led;

endmodule

// File: tb/tb_frame_loader.sv
`timescale 1ns/1ps
// Bench for frame_loader: randomized byte streams checked against a frame-level
// model (sent bytes followed by zero padding) and the documented event timing.
module tb_frame_loader;

  localparam int PIX = 256;
  localparam int TO  = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       wr_en, wr_bank, disp_bank, frame_done, timeout, overrun;
  logic [7:0] wr_addr, wr_data;
  logic [1:0] led_state;

  frame_loader #(.PIXELS(PIX), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .disp_bank(disp_bank), .frame_done(frame_done), .timeout(timeout),
    .overrun(overrun), .led_state(led_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame RAM stand-in plus event counters, sampled 2 ns after each rising edge.
  logic [7:0] mon_mem [2][PIX];
  bit         mon_wr  [2][PIX];
  int wr_cnt = 0, fd_cnt = 0, to_cnt = 0, ov_cnt = 0;

  always begin
    @(posedge clk);
    #2;
    if (!rst) begin
      if (wr_en) begin
        mon_mem[wr_bank][wr_addr] = wr_data;
        mon_wr[wr_bank][wr_addr]  = 1'b1;
        wr_cnt++;
      end
      if (frame_done) fd_cnt++;
      if (timeout)    to_cnt++;
      if (overrun)    ov_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge; strobes for one cycle and returns at the next
  // falling edge, when the resulting write is visible.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 6)) @(negedge clk);
  endtask

  task automatic clear_mon(input int bank);
    for (int i = 0; i < PIX; i++) mon_wr[bank][i] = 1'b0;
  endtask

  // Expected frame: the received bytes in order, zero beyond them.
  function automatic int model_mismatch(input int bank, input logic [7:0] q[$]);
    int n = 0;
    for (int i = 0; i < PIX; i++) begin
      logic [7:0] e;
      e = (i < q.size()) ? q[i] : 8'h00;
      if (!mon_wr[bank][i] || mon_mem[bank][i] !== e) n++;
    end
    return n;
  endfunction

  task automatic wait_frame_done(input string tag, input int budget);
    int n = 0;
    while (frame_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, frame_done, 1);
  endtask

  function automatic logic [23:0] outv();
    return {wr_en, wr_bank, wr_addr, wr_data, disp_bank, frame_done,
            timeout, overrun, led_state};
  endfunction

  localparam logic [23:0] RESET_V = {1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0,
                                     1'b0, 1'b0, 2'b00};

  initial begin
    int w0, f0, t0, o0, bad, n;
    logic [7:0] b, b1;
    logic [7:0] q[$];

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a cycle while loading
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)));
    check("pre_reset_wr_en", wr_en, 1);
    check("pre_reset_led", led_state, 2'b01);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", outv(), RESET_V);
    check("async_reset_led", led_state, 2'b00);
    @(negedge clk);
    check("reset_held_outputs", outv(), RESET_V);
    rst = 1'b0;
    @(negedge clk);

    // Full frame 0..255 into bank 1
    clear_mon(1);
    q = {};
    for (int i = 0; i < PIX; i++) q.push_back(8'(i));
    w0 = wr_cnt; f0 = fd_cnt;
    for (int i = 0; i < PIX; i++) begin
      send_byte(8'(i));
      if (i < PIX - 1) gap();
    end
    check("full_last_write", {wr_en, wr_bank, wr_addr, wr_data}, {1'b1, 1'b1, 8'hFF, 8'hFF});
    check("full_pre_swap_disp", disp_bank, 0);
    check("full_pre_swap_done", frame_done, 0);
    @(negedge clk);
    check("full_frame_done", frame_done, 1);
    check("full_disp_bank", disp_bank, 1);
    check("full_led_display", led_state, 2'b10);
    check("full_wr_single_cycle", wr_en, 0);
    @(negedge clk);
    check("full_done_one_cycle", frame_done, 0);
    check("full_wr_count", wr_cnt - w0, PIX);
    check("full_done_count", fd_cnt - f0, 1);
    check("full_bank1_data", model_mismatch(1, q), 0);

    // Reload 0x5A while the previous frame stays displayed
    clear_mon(0);
    q = {};
    bad = 0;
    w0 = wr_cnt; f0 = fd_cnt;
    for (int i = 0; i < PIX; i++) begin
      q.push_back(8'h5A);
      send_byte(8'h5A);
      if (disp_bank !== 1'b1 || led_state !== 2'b01 || wr_bank !== 1'b0) bad++;
      if (i < PIX - 1) gap();
    end
    check("reload_disp_led_held", bad, 0);
    @(negedge clk);
    check("reload_frame_done", frame_done, 1);
    check("reload_disp_bank", disp_bank, 0);
    @(negedge clk);
    check("reload_done_count", fd_cnt - f0, 1);
    check("reload_bank0_data", model_mismatch(0, q), 0);

    // Short frame: one byte, timeout, zero fill of 1..255, swap
    clear_mon(1);
    b = 8'($urandom_range(1, 255));
    q = {b};
    w0 = wr_cnt; t0 = to_cnt;
    send_byte(b);
    check("short_first_write", {wr_en, wr_bank, wr_addr, wr_data}, {1'b1, 1'b1, 8'h00, b});
    repeat (TO - 1) @(negedge clk);
    check("short_no_early_timeout", timeout, 0);
    @(negedge clk);
    check("short_timeout_pulse", timeout, 1);
    check("short_led_loading", led_state, 2'b01);
    bad = 0;
    for (int a = 1; a < PIX; a++) begin
      @(negedge clk);
      if (wr_en !== 1'b1 || wr_addr !== 8'(a) || wr_data !== 8'h00 || timeout !== 1'b0) bad++;
    end
    check("short_fill_sequence", bad, 0);
    @(negedge clk);
    check("short_frame_done", frame_done, 1);
    check("short_disp_bank", disp_bank, 1);
    check("short_led_display", led_state, 2'b10);
    @(negedge clk);
    check("short_timeout_count", to_cnt - t0, 1);
    check("short_wr_count", wr_cnt - w0, PIX);
    check("short_bank1_data", model_mismatch(1, q), 0);

    // Byte arriving during FILL is dropped
    clear_mon(0);
    b = 8'($urandom_range(0, 255));
    q = {b};
    w0 = wr_cnt; o0 = ov_cnt;
    send_byte(b);
    n = 0;
    while (timeout !== 1'b1 && n < TO + 5) begin
      @(negedge clk);
      n++;
    end
    check("ovr_timeout_seen", timeout, 1);
    repeat (10) @(negedge clk);
    send_byte(8'($urandom_range(1, 255)));
    check("ovr_overrun_pulse", overrun, 1);
    @(negedge clk);
    check("ovr_overrun_one_cycle", overrun, 0);
    wait_frame_done("ovr_frame_done", PIX + 10);
    check("ovr_disp_bank", disp_bank, 0);
    @(negedge clk);
    check("ovr_overrun_count", ov_cnt - o0, 1);
    check("ovr_wr_count", wr_cnt - w0, PIX);
    check("ovr_bank0_data", model_mismatch(0, q), 0);

    // Byte coinciding with the timeout expiry cycle is accepted
    clear_mon(1);
    b  = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    q = {b, b1};
    t0 = to_cnt; o0 = ov_cnt;
    send_byte(b);
    repeat (TO - 1) @(negedge clk);
    send_byte(b1);
    check("race_byte_written", {wr_en, wr_bank, wr_addr, wr_data}, {1'b1, 1'b1, 8'h01, b1});
    check("race_no_timeout", timeout, 0);
    @(negedge clk);
    check("race_no_timeout_after", to_cnt - t0, 0);
    wait_frame_done("race_frame_done", TO + PIX + 10);
    check("race_disp_bank", disp_bank, 1);
    @(negedge clk);
    check("race_timeout_count", to_cnt - t0, 1);
    check("race_overrun_count", ov_cnt - o0, 0);
    check("race_bank1_data", model_mismatch(1, q), 0);

    // Reset after 100 bytes abandons the frame; the next one starts over
    for (int i = 0; i < 100; i++) begin
      send_byte(8'($urandom_range(0, 255)));
      if (i < 99) gap();
    end
    check("midload_led_loading", led_state, 2'b01);
    #2 rst = 1'b1;
    #1 check("midload_reset_outputs", outv(), RESET_V);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_mon(1);
    q = {8'h11};
    f0 = fd_cnt;
    send_byte(8'h11);
    check("after_reset_write", {wr_en, wr_bank, wr_addr, wr_data}, {1'b1, 1'b1, 8'h00, 8'h11});
    check("after_reset_led", led_state, 2'b01);
    for (int i = 1; i < PIX - 1; i++) begin
      gap();
      b = 8'($urandom_range(0, 255));
      q.push_back(b);
      send_byte(b);
    end
    @(negedge clk);
    check("after_reset_no_early_done", fd_cnt - f0, 0);
    b = 8'($urandom_range(0, 255));
    q.push_back(b);
    send_byte(b);
    @(negedge clk);
    check("after_reset_frame_done", frame_done, 1);
    check("after_reset_disp_bank", disp_bank, 1);
    @(negedge clk);
    check("after_reset_bank1_data", model_mismatch(1, q), 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
